// File: rtl/writeback_unit_if.sv
// Bundle of the writeback stage's pipeline and data-memory signals.
// Handshake: the upstream stage presents an instruction with valid_i and holds
// every instruction field stable until a cycle where valid_i and ready_o are both
// high; that cycle is the transfer. valid_i is ignored while ready_o is low.
// mem_req_o/mem_addr_o stay stable until mem_ack_i is sampled high.
interface writeback_unit_if #(
  parameter int ADDR_SIZE     = 5,
  parameter int WORD_SIZE     = 32,
  parameter int MEM_ADDR_SIZE = 32
);
  logic                     valid_i;
  logic                     ready_o;
  logic [WORD_SIZE-1:0]     alu_data_i;
  logic [ADDR_SIZE-1:0]     rd_addr_i;
  logic                     rd_we_i;
  logic                     is_load_i;
  logic [1:0]               ld_size_i;
  logic                     ld_unsigned_i;
  logic                     mem_req_o;
  logic [MEM_ADDR_SIZE-1:0] mem_addr_o;
  logic                     mem_ack_i;
  logic [WORD_SIZE-1:0]     mem_data_i;
  logic                     rf_we_o;
  logic [ADDR_SIZE-1:0]     rf_addr_o;
  logic [WORD_SIZE-1:0]     rf_data_o;
  logic                     err_o;

  // Writeback unit side.
  modport slave (
    input  valid_i, alu_data_i, rd_addr_i, rd_we_i, is_load_i, ld_size_i,
           ld_unsigned_i, mem_ack_i, mem_data_i,
    output ready_o, mem_req_o, mem_addr_o, rf_we_o, rf_addr_o, rf_data_o, err_o
  );

  // Environment side: upstream stage, data memory and register file.
  modport master (
    output valid_i, alu_data_i, rd_addr_i, rd_we_i, is_load_i, ld_size_i,
           ld_unsigned_i, mem_ack_i, mem_data_i,
    input  ready_o, mem_req_o, mem_addr_o, rf_we_o, rf_addr_o, rf_data_o, err_o
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: registers ALU results, runs loads against a variable-latency
// data memory (with alignment, lane selection, extension and a timeout), and
// stalls the upstream stage while a load is outstanding.
module writeback_unit #(
  parameter int ADDR_SIZE     = 5,
  parameter int WORD_SIZE     = 32,
  parameter int MEM_ADDR_SIZE = 32,
  parameter int BIG_ENDIAN    = 0,
  parameter int TIMEOUT       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  writeback_unit_if.slave  bus,
  output logic             o_dbg_state   // 1 while a load is outstanding
);

  localparam int NBYTES = WORD_SIZE / 8;
  localparam int LB     = $clog2(NBYTES);
  localparam int CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_FULL = 2'b11;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t                   r_state,    w_state_nxt;
  logic [CW-1:0]            r_cnt,      w_cnt_nxt;
  logic                     r_mem_req,  w_mem_req_nxt;
  logic [MEM_ADDR_SIZE-1:0] r_mem_addr, w_mem_addr_nxt;
  logic                     r_rf_we,    w_rf_we_nxt;
  logic [ADDR_SIZE-1:0]     r_rf_addr,  w_rf_addr_nxt;
  logic [WORD_SIZE-1:0]     r_rf_data,  w_rf_data_nxt;
  logic                     r_err,      w_err_nxt;
  logic [LB-1:0]            r_ld_off,   w_ld_off_nxt;
  logic [1:0]               r_ld_size,  w_ld_size_nxt;
  logic                     r_ld_uns,   w_ld_uns_nxt;
  logic [ADDR_SIZE-1:0]     r_ld_rd,    w_ld_rd_nxt;
  logic                     r_ld_we,    w_ld_we_nxt;

  logic                 w_ready;
  logic                 w_xfer;
  logic [LB-1:0]        w_in_off;
  logic                 w_misaligned;
  logic [LB:0]          w_sz;
  logic [7:0]           w_nbits;
  logic [LB:0]          w_lane;
  logic [WORD_SIZE-1:0] w_shifted;
  logic [WORD_SIZE-1:0] w_mask;
  logic [WORD_SIZE-1:0] w_top;
  logic                 w_sign;
  logic [WORD_SIZE-1:0] w_ld_data;

  assign w_ready  = (r_state == S_IDLE) & ~rst_i;
  assign w_xfer   = bus.valid_i & w_ready;
  assign w_in_off = bus.alu_data_i[LB-1:0];

  // Alignment check of the incoming load address against its access size.
  always_comb begin
    w_misaligned = 1'b0;
    case (bus.ld_size_i)
      SZ_HALF: w_misaligned = w_in_off[0];
      SZ_WORD: w_misaligned = |w_in_off[1:0];
      SZ_FULL: w_misaligned = |w_in_off;
      default: w_misaligned = 1'b0;
    endcase
  end

  // Load data extraction: pick the byte lanes, right-justify, then extend.
  // The mask/top-bit form keeps this width-agnostic for 32- and 64-bit words.
  always_comb begin
    w_sz    = (LB+1)'(1);
    w_nbits = 8'd8;
    case (r_ld_size)
      SZ_BYTE: begin w_sz = (LB+1)'(1);      w_nbits = 8'd8;               end
      SZ_HALF: begin w_sz = (LB+1)'(2);      w_nbits = 8'd16;              end
      SZ_WORD: begin w_sz = (LB+1)'(4);      w_nbits = 8'd32;              end
      default: begin w_sz = (LB+1)'(NBYTES); w_nbits = 8'(WORD_SIZE);      end
    endcase
    if (BIG_ENDIAN != 0) w_lane = (LB+1)'(NBYTES) - w_sz - {1'b0, r_ld_off};
    else                 w_lane = {1'b0, r_ld_off};
    w_shifted = bus.mem_data_i >> {w_lane, 3'b000};
    w_mask    = ~({WORD_SIZE{1'b1}} << w_nbits);
    w_top     = w_mask & ~(w_mask >> 1);
    w_sign    = ~r_ld_uns & (|(w_shifted & w_top));
    w_ld_data = (w_shifted & w_mask) | (w_sign ? ~w_mask : '0);
  end

  // Next-state and next-output logic; pulses default low, data holds.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_mem_req_nxt  = r_mem_req;
    w_mem_addr_nxt = r_mem_addr;
    w_rf_we_nxt    = 1'b0;
    w_rf_addr_nxt  = r_rf_addr;
    w_rf_data_nxt  = r_rf_data;
    w_err_nxt      = 1'b0;
    w_ld_off_nxt   = r_ld_off;
    w_ld_size_nxt  = r_ld_size;
    w_ld_uns_nxt   = r_ld_uns;
    w_ld_rd_nxt    = r_ld_rd;
    w_ld_we_nxt    = r_ld_we;
    case (r_state)
      S_IDLE: begin
        if (w_xfer && !bus.is_load_i) begin
          if (bus.rd_we_i && (bus.rd_addr_i != '0)) begin
            w_rf_we_nxt   = 1'b1;
            w_rf_addr_nxt = bus.rd_addr_i;
            w_rf_data_nxt = bus.alu_data_i;
          end
        end else if (w_xfer) begin
          w_ld_off_nxt  = w_in_off;
          w_ld_size_nxt = bus.ld_size_i;
          w_ld_uns_nxt  = bus.ld_unsigned_i;
          w_ld_rd_nxt   = bus.rd_addr_i;
          w_ld_we_nxt   = bus.rd_we_i;
          if (w_misaligned) begin
            w_err_nxt = 1'b1;
          end else begin
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = bus.alu_data_i[MEM_ADDR_SIZE-1:0];
            w_cnt_nxt      = '0;
            w_state_nxt    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.mem_ack_i) begin
          // An ack on the final timeout cycle still completes the load.
          if (r_ld_we && (r_ld_rd != '0)) begin
            w_rf_we_nxt   = 1'b1;
            w_rf_addr_nxt = r_ld_rd;
            w_rf_data_nxt = w_ld_data;
          end
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end else if ((TIMEOUT != 0) && (r_cnt == CNT_LAST)) begin
          w_err_nxt     = 1'b1;
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; reset abandons any outstanding load.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_mem_req  <= 1'b0;
      r_mem_addr <= '0;
      r_rf_we    <= 1'b0;
      r_rf_addr  <= '0;
      r_rf_data  <= '0;
      r_err      <= 1'b0;
      r_ld_off   <= '0;
      r_ld_size  <= '0;
      r_ld_uns   <= 1'b0;
      r_ld_rd    <= '0;
      r_ld_we    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_mem_req  <= w_mem_req_nxt;
      r_mem_addr <= w_mem_addr_nxt;
      r_rf_we    <= w_rf_we_nxt;
      r_rf_addr  <= w_rf_addr_nxt;
      r_rf_data  <= w_rf_data_nxt;
      r_err      <= w_err_nxt;
      r_ld_off   <= w_ld_off_nxt;
      r_ld_size  <= w_ld_size_nxt;
      r_ld_uns   <= w_ld_uns_nxt;
      r_ld_rd    <= w_ld_rd_nxt;
      r_ld_we    <= w_ld_we_nxt;
    end
  end

  assign bus.ready_o    = w_ready;
  assign bus.mem_req_o  = r_mem_req;
  assign bus.mem_addr_o = r_mem_addr;
  assign bus.rf_we_o    = r_rf_we;
  assign bus.rf_addr_o  = r_rf_addr;
  assign bus.rf_data_o  = r_rf_data;
  assign bus.err_o      = r_err;
  assign o_dbg_state    = (r_state == S_WAIT);

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: a little-endian and a big-endian instance driven in
// lockstep, with a reference model of load extraction and a write scoreboard.
module tb_writeback_unit;

  localparam int AW = 5;
  localparam int WW = 32;
  localparam int MW = 32;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          valid, rd_we, is_load, ld_uns, mem_ack;
  logic [WW-1:0] alu_data, mem_data;
  logic [AW-1:0] rd_addr;
  logic [1:0]    ld_size;
  logic          dbg_le, dbg_be;

  writeback_unit_if #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .MEM_ADDR_SIZE(MW)) bus_le ();
  writeback_unit_if #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .MEM_ADDR_SIZE(MW)) bus_be ();

  assign bus_le.valid_i = valid;       assign bus_be.valid_i = valid;
  assign bus_le.alu_data_i = alu_data; assign bus_be.alu_data_i = alu_data;
  assign bus_le.rd_addr_i = rd_addr;   assign bus_be.rd_addr_i = rd_addr;
  assign bus_le.rd_we_i = rd_we;       assign bus_be.rd_we_i = rd_we;
  assign bus_le.is_load_i = is_load;   assign bus_be.is_load_i = is_load;
  assign bus_le.ld_size_i = ld_size;   assign bus_be.ld_size_i = ld_size;
  assign bus_le.ld_unsigned_i = ld_uns; assign bus_be.ld_unsigned_i = ld_uns;
  assign bus_le.mem_ack_i = mem_ack;   assign bus_be.mem_ack_i = mem_ack;
  assign bus_le.mem_data_i = mem_data; assign bus_be.mem_data_i = mem_data;

  writeback_unit #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .MEM_ADDR_SIZE(MW),
                   .BIG_ENDIAN(0), .TIMEOUT(TO))
    dut_le (.clk_i(clk), .rst_i(rst), .bus(bus_le), .o_dbg_state(dbg_le));

  writeback_unit #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .MEM_ADDR_SIZE(MW),
                   .BIG_ENDIAN(1), .TIMEOUT(TO))
    dut_be (.clk_i(clk), .rst_i(rst), .bus(bus_be), .o_dbg_state(dbg_be));

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check2(input string tag, input logic [63:0] obs_le, input logic [63:0] obs_be,
                        input logic [63:0] exp_le, input logic [63:0] exp_be);
    check({tag, "_le"}, obs_le, exp_le);
    check({tag, "_be"}, obs_be, exp_be);
  endtask

  // ---------------- reference model ----------------
  function automatic bit model_misaligned(input logic [31:0] addr, input logic [1:0] size);
    case (size)
      2'd1:    return (addr % 2) != 0;
      2'd2,
      2'd3:    return (addr % 4) != 0;
      default: return 1'b0;
    endcase
  endfunction

  // Byte start of the loaded item in the memory word, little-endian numbering.
  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                             input logic uns, input logic [31:0] data, input bit be);
    longint unsigned nb, off, start, v, half, full;
    nb    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    off   = addr % 4;
    start = be ? (4 - nb - off) : off;
    full  = longint'(1) << (8 * nb);
    half  = full / 2;
    v     = (longint'(data) / (longint'(1) << (8 * start))) % full;
    if (!uns && v >= half) v = v + (longint'(1) << 32) - full;
    return v[31:0];
  endfunction

  // ---------------- scoreboard ----------------
  logic [AW+WW-1:0] exp_q_le[$];
  logic [AW+WW-1:0] exp_q_be[$];
  logic [AW+WW-1:0] last_le = '0;
  logic [AW+WW-1:0] last_be = '0;
  logic [AW+WW-1:0] e_le, e_be;

  task automatic expect_write(input logic [AW-1:0] rd, input logic we,
                              input logic [31:0] d_le, input logic [31:0] d_be);
    if (we && rd != 0) begin
      exp_q_le.push_back({rd, d_le});
      exp_q_be.push_back({rd, d_be});
      last_le = {rd, d_le};
      last_be = {rd, d_be};
    end
  endtask

  always @(negedge clk) begin
    if (bus_le.rf_we_o) begin
      if (exp_q_le.size() == 0) check("le_unexpected_write", bus_le.rf_we_o, 0);
      else begin
        e_le = exp_q_le.pop_front();
        check("le_write", {bus_le.rf_addr_o, bus_le.rf_data_o}, e_le);
      end
    end
    if (bus_be.rf_we_o) begin
      if (exp_q_be.size() == 0) check("be_unexpected_write", bus_be.rf_we_o, 0);
      else begin
        e_be = exp_q_be.pop_front();
        check("be_write", {bus_be.rf_addr_o, bus_be.rf_data_o}, e_be);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_hold(input string tag);
    check2(tag, {bus_le.rf_addr_o, bus_le.rf_data_o}, {bus_be.rf_addr_o, bus_be.rf_data_o},
           last_le, last_be);
  endtask

  task automatic alu_op(input logic [AW-1:0] rd, input logic we, input logic [31:0] data);
    bit wr;
    wr = we && (rd != 0);
    valid = 1'b1; is_load = 1'b0; rd_addr = rd; rd_we = we; alu_data = data;
    ld_size = 2'($urandom_range(0, 3)); ld_uns = 1'($urandom_range(0, 1));
    check2("alu_ready_pre", bus_le.ready_o, bus_be.ready_o, 1, 1);
    expect_write(rd, we, data, data);
    step();
    valid = 1'b0;
    check2("alu_we", bus_le.rf_we_o, bus_be.rf_we_o, 64'(wr), 64'(wr));
    check2("alu_ready_post", bus_le.ready_o, bus_be.ready_o, 1, 1);
    check2("alu_no_req", bus_le.mem_req_o, bus_be.mem_req_o, 0, 0);
    check_hold("alu_rf_out");
  endtask

  // ack_at: WAIT-cycle index (0-based) on which the memory acks; >= TO never acks.
  task automatic load_op(input logic [31:0] addr, input logic [1:0] size, input logic uns,
                         input logic [AW-1:0] rd, input logic we, input logic [31:0] data,
                         input int ack_at);
    bit wr;
    wr = we && (rd != 0);
    valid = 1'b1; is_load = 1'b1; rd_addr = rd; rd_we = we; alu_data = addr;
    ld_size = size; ld_uns = uns;
    check2("ld_ready_pre", bus_le.ready_o, bus_be.ready_o, 1, 1);
    step();
    valid = 1'b0; alu_data = $urandom; rd_addr = 5'($urandom_range(0, 31));
    if (model_misaligned(addr, size)) begin
      check2("mis_err", bus_le.err_o, bus_be.err_o, 1, 1);
      check2("mis_no_req", bus_le.mem_req_o, bus_be.mem_req_o, 0, 0);
      check2("mis_no_we", bus_le.rf_we_o, bus_be.rf_we_o, 0, 0);
      check2("mis_ready", bus_le.ready_o, bus_be.ready_o, 1, 1);
      check_hold("mis_rf_out");
      step();
      check2("mis_err_pulse", bus_le.err_o, bus_be.err_o, 0, 0);
      check2("mis_no_req2", bus_le.mem_req_o, bus_be.mem_req_o, 0, 0);
      return;
    end
    check2("ld_err_low", bus_le.err_o, bus_be.err_o, 0, 0);
    for (int c = 0; c < TO; c++) begin
      check2("wait_req", bus_le.mem_req_o, bus_be.mem_req_o, 1, 1);
      check2("wait_addr", bus_le.mem_addr_o, bus_be.mem_addr_o, addr, addr);
      check2("wait_ready", bus_le.ready_o, bus_be.ready_o, 0, 0);
      check2("wait_dbg", dbg_le, dbg_be, 1, 1);
      check2("wait_no_we", bus_le.rf_we_o, bus_be.rf_we_o, 0, 0);
      mem_ack  = (c == ack_at);
      mem_data = (c == ack_at) ? data : $urandom;
      if (c == ack_at)
        expect_write(rd, we, model_load(addr, size, uns, data, 1'b0),
                     model_load(addr, size, uns, data, 1'b1));
      step();
      mem_ack = 1'b0;
      if (c == ack_at) begin
        check2("ack_we", bus_le.rf_we_o, bus_be.rf_we_o, 64'(wr), 64'(wr));
        check2("ack_no_err", bus_le.err_o, bus_be.err_o, 0, 0);
        check2("ack_req_low", bus_le.mem_req_o, bus_be.mem_req_o, 0, 0);
        check2("ack_ready", bus_le.ready_o, bus_be.ready_o, 1, 1);
        check_hold("ack_rf_out");
        return;
      end
    end
    check2("to_err", bus_le.err_o, bus_be.err_o, 1, 1);
    check2("to_req_low", bus_le.mem_req_o, bus_be.mem_req_o, 0, 0);
    check2("to_no_we", bus_le.rf_we_o, bus_be.rf_we_o, 0, 0);
    check2("to_ready", bus_le.ready_o, bus_be.ready_o, 1, 1);
    check_hold("to_rf_out");
    mem_ack = 1'b1; mem_data = $urandom;
    step();
    mem_ack = 1'b0;
    check2("idle_ack_ignored", bus_le.rf_we_o, bus_be.rf_we_o, 0, 0);
    check2("to_err_pulse", bus_le.err_o, bus_be.err_o, 0, 0);
    check2("idle_ack_ready", bus_le.ready_o, bus_be.ready_o, 1, 1);
  endtask

  task automatic reset_mid_wait();
    valid = 1'b1; is_load = 1'b1; rd_addr = 5'd12; rd_we = 1'b1; alu_data = 32'h0000_0200;
    ld_size = 2'd2; ld_uns = 1'b0;
    step();
    valid = 1'b0;
    step();
    check2("rst_pre_req", bus_le.mem_req_o, bus_be.mem_req_o, 1, 1);
    rst = 1'b1;
    #1;
    check2("rst_ready_low", bus_le.ready_o, bus_be.ready_o, 0, 0);
    step();
    last_le = '0; last_be = '0;
    check2("rst_req_low", bus_le.mem_req_o, bus_be.mem_req_o, 0, 0);
    check2("rst_no_we", bus_le.rf_we_o, bus_be.rf_we_o, 0, 0);
    check2("rst_dbg", dbg_le, dbg_be, 0, 0);
    check_hold("rst_rf_cleared");
    rst = 1'b0;
    mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
    step();
    mem_ack = 1'b0;
    check2("rst_late_ack", bus_le.rf_we_o, bus_be.rf_we_o, 0, 0);
    alu_op(5'd13, 1'b1, 32'hCAFE_0013);
    alu_op(5'd14, 1'b1, 32'hCAFE_0014);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; valid = 1'b0; rd_we = 1'b0; is_load = 1'b0; ld_uns = 1'b0; mem_ack = 1'b0;
    alu_data = '0; mem_data = '0; rd_addr = '0; ld_size = '0;
    repeat (3) step();
    check2("rst_ready", bus_le.ready_o, bus_be.ready_o, 0, 0);
    check2("rst_req", bus_le.mem_req_o, bus_be.mem_req_o, 0, 0);
    check2("rst_addr", bus_le.mem_addr_o, bus_be.mem_addr_o, 0, 0);
    check2("rst_we", bus_le.rf_we_o, bus_be.rf_we_o, 0, 0);
    check2("rst_rf", {bus_le.rf_addr_o, bus_le.rf_data_o}, {bus_be.rf_addr_o, bus_be.rf_data_o}, 0, 0);
    check2("rst_err", bus_le.err_o, bus_be.err_o, 0, 0);
    check2("rst_state", dbg_le, dbg_be, 0, 0);
    rst = 1'b0;
    #1;
    check2("post_rst_ready", bus_le.ready_o, bus_be.ready_o, 1, 1);

    alu_op(5'd7, 1'b1, 32'h1234_5678);
    check2("t1_data", bus_le.rf_data_o, bus_be.rf_data_o, 32'h1234_5678, 32'h1234_5678);

    load_op(32'h103, 2'd0, 1'b0, 5'd3, 1'b1, 32'h80FF_0000, 3);
    check2("t2_data", bus_le.rf_data_o, bus_be.rf_data_o, 32'hFFFF_FF80, 32'h0000_0000);

    load_op(32'h2, 2'd1, 1'b1, 5'd4, 1'b1, 32'hBEEF_1234, 0);
    check2("t3_data", bus_le.rf_data_o, bus_be.rf_data_o, 32'h0000_BEEF, 32'h0000_1234);
    load_op(32'h1, 2'd1, 1'b1, 5'd4, 1'b1, 32'hBEEF_1234, 0);

    load_op(32'h40, 2'd2, 1'b0, 5'd5, 1'b1, 32'h1111_2222, TO);
    load_op(32'h44, 2'd2, 1'b0, 5'd6, 1'b1, 32'h8765_4321, TO - 1);
    check2("t4_data", bus_le.rf_data_o, bus_be.rf_data_o, 32'h8765_4321, 32'h8765_4321);
    load_op(32'h48, 2'd3, 1'b1, 5'd8, 1'b1, 32'hA5A5_5A5A, 1);
    load_op(32'h4A, 2'd3, 1'b1, 5'd8, 1'b1, 32'hA5A5_5A5A, 1);

    reset_mid_wait();

    load_op(32'h10, 2'd2, 1'b0, 5'd0, 1'b1, 32'h0BAD_F00D, 2);
    alu_op(5'd9, 1'b0, 32'h0000_0099);

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      logic [1:0]  sz;
      int          ack;
      a  = 32'($urandom_range(0, 1023));
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) < 7) a = a & ~32'(sz == 2'd0 ? 0 : sz == 2'd1 ? 1 : 3);
      ack = ($urandom_range(0, 9) == 0) ? $urandom_range(TO - 1, TO) : $urandom_range(0, 4);
      if ($urandom_range(0, 2) == 0)
        alu_op(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom);
      else
        load_op(a, sz, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                1'($urandom_range(0, 3) != 0), $urandom, ack);
      if ($urandom_range(0, 1) == 1) step();
    end

    step();
    step();
    check("exp_q_le_drained", 64'(exp_q_le.size()), 0);
    check("exp_q_be_drained", 64'(exp_q_be.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
